// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller.
// Detects load-use hazards (bubble), resolves taken-branch flushes, and freezes
// the pipeline while an EX/MEM load/store waits on a data-memory handshake.
// Saturating counters track stall and flush cycles.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   idExMemRead_i, idExRd_i ID/EX load flag and destination register
//   ifIdRs1_i, ifIdRs2_i   IF/ID source registers
//   branchTaken_i          branch resolved taken in ID
//   exMemMemRead_i/Write_i EX/MEM memory access flags
//   memAck_i               data memory access complete
//   hazardDetected_o       zero the ID/EX control word (combinational)
//   pcWrite_o, ifIdWrite_o PC / IF/ID update enables (combinational)
//   ifIdFlush_o            clear IF/ID to a NOP (combinational)
//   pipeStall_o            freeze all pipeline registers (combinational)
//   memReq_o               registered data memory request
//   stallCount_o           stall/bubble cycle counter
//   flushCount_o           flush cycle counter
module hazard_ctrl #(
   parameter int unsigned COUNT_W = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               idExMemRead_i,
   input  logic [4:0]         idExRd_i,
   input  logic [4:0]         ifIdRs1_i,
   input  logic [4:0]         ifIdRs2_i,
   input  logic               branchTaken_i,
   input  logic               exMemMemRead_i,
   input  logic               exMemMemWrite_i,
   input  logic               memAck_i,
   output logic               hazardDetected_o,
   output logic               pcWrite_o,
   output logic               ifIdWrite_o,
   output logic               ifIdFlush_o,
   output logic               pipeStall_o,
   output logic               memReq_o,
   output logic [COUNT_W-1:0] stallCount_o,
   output logic [COUNT_W-1:0] flushCount_o
);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t nextState;
   logic   memAccess;
   logic   loadUse;
   logic   pipeStall;
   logic   hazard;
   logic   flush;

   assign memAccess = exMemMemRead_i | exMemMemWrite_i;

   assign loadUse = idExMemRead_i & (idExRd_i != 5'd0) &
                    ((idExRd_i == ifIdRs1_i) | (idExRd_i == ifIdRs2_i));

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= RUN;
      else       state <= nextState;
   end

   // Next state and freeze; DONE ignores memAccess so the retiring access is not re-requested
   always_comb begin
      nextState = state;
      pipeStall = 1'b0;
      case (state)
         RUN: begin
            if (memAccess) begin
               pipeStall = 1'b1;
               nextState = WAIT;
            end
         end
         WAIT: begin
            pipeStall = 1'b1;
            if (memAck_i) nextState = DONE;
         end
         DONE: begin
            nextState = RUN;
         end
         default: begin
            nextState = RUN;
         end
      endcase
   end

   // Priority: memory freeze over load-use bubble over branch flush
   assign hazard = loadUse & ~pipeStall;
   assign flush  = branchTaken_i & ~pipeStall & ~hazard;

   assign pipeStall_o      = pipeStall;
   assign hazardDetected_o = hazard;
   assign pcWrite_o        = ~(pipeStall | hazard);
   assign ifIdWrite_o      = ~(pipeStall | hazard);
   assign ifIdFlush_o      = flush;

   // Request flop is high exactly while in WAIT
   always_ff @(posedge clk_i) begin
      if (rst_i) memReq_o <= 1'b0;
      else       memReq_o <= (nextState == WAIT);
   end

   // Saturating performance counters
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stallCount_o <= '0;
         flushCount_o <= '0;
      end else begin
         if ((pipeStall | hazard) && !(&stallCount_o))
            stallCount_o <= stallCount_o + COUNT_W'(1);
         if (flush && !(&flushCount_o))
            flushCount_o <= flushCount_o + COUNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; a second instance with
// 4-bit counters shares the stimulus to exercise saturation.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        idExMemRead = 1'b0;
   logic [4:0]  idExRd = 5'd0;
   logic [4:0]  ifIdRs1 = 5'd0;
   logic [4:0]  ifIdRs2 = 5'd0;
   logic        branchTaken = 1'b0;
   logic        exMemMemRead = 1'b0;
   logic        exMemMemWrite = 1'b0;
   logic        memAck = 1'b0;

   logic        hazard, pcWrite, ifIdWrite, flush, stall, memReq;
   logic [31:0] stallCnt, flushCnt;
   logic        hazardS, pcWriteS, ifIdWriteS, flushS, stallS, memReqS;
   logic [3:0]  stallCntS, flushCntS;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk_i(clk), .rst_i(rst),
      .idExMemRead_i(idExMemRead), .idExRd_i(idExRd),
      .ifIdRs1_i(ifIdRs1), .ifIdRs2_i(ifIdRs2),
      .branchTaken_i(branchTaken),
      .exMemMemRead_i(exMemMemRead), .exMemMemWrite_i(exMemMemWrite),
      .memAck_i(memAck),
      .hazardDetected_o(hazard), .pcWrite_o(pcWrite), .ifIdWrite_o(ifIdWrite),
      .ifIdFlush_o(flush), .pipeStall_o(stall), .memReq_o(memReq),
      .stallCount_o(stallCnt), .flushCount_o(flushCnt)
   );

   hazard_ctrl #(.COUNT_W(4)) dutSat (
      .clk_i(clk), .rst_i(rst),
      .idExMemRead_i(idExMemRead), .idExRd_i(idExRd),
      .ifIdRs1_i(ifIdRs1), .ifIdRs2_i(ifIdRs2),
      .branchTaken_i(branchTaken),
      .exMemMemRead_i(exMemMemRead), .exMemMemWrite_i(exMemMemWrite),
      .memAck_i(memAck),
      .hazardDetected_o(hazardS), .pcWrite_o(pcWriteS), .ifIdWrite_o(ifIdWriteS),
      .ifIdFlush_o(flushS), .pipeStall_o(stallS), .memReq_o(memReqS),
      .stallCount_o(stallCntS), .flushCount_o(flushCntS)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clearIn();
      idExMemRead = 1'b0; idExRd = 5'd0; ifIdRs1 = 5'd0; ifIdRs2 = 5'd0;
      branchTaken = 1'b0; exMemMemRead = 1'b0; exMemMemWrite = 1'b0; memAck = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset then idle
      clearIn();
      rst = 1'b1;
      tick(); tick();
      chk("rst_pcWrite", 32'(pcWrite), 32'd1);
      chk("rst_ifIdWrite", 32'(ifIdWrite), 32'd1);
      chk("rst_hazard", 32'(hazard), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_memReq", 32'(memReq), 32'd0);
      chk("rst_stallCnt", stallCnt, 32'd0);
      chk("rst_flushCnt", flushCnt, 32'd0);
      rst = 1'b0;
      tick();
      chk("idle_stallCnt", stallCnt, 32'd0);
      chk("idle_pcWrite", 32'(pcWrite), 32'd1);

      // Load-use on rs2
      idExMemRead = 1'b1; idExRd = 5'd5; ifIdRs2 = 5'd5; #1;
      chk("lu2_hazard", 32'(hazard), 32'd1);
      chk("lu2_pcWrite", 32'(pcWrite), 32'd0);
      chk("lu2_ifIdWrite", 32'(ifIdWrite), 32'd0);
      chk("lu2_stall", 32'(stall), 32'd0);
      tick();
      clearIn(); #1;
      chk("lu2_stallCnt", stallCnt, 32'd1);
      // Load-use on rs1
      idExMemRead = 1'b1; idExRd = 5'd7; ifIdRs1 = 5'd7; #1;
      chk("lu1_hazard", 32'(hazard), 32'd1);
      tick();
      clearIn(); #1;
      chk("lu1_stallCnt", stallCnt, 32'd2);
      // x0 destination never hazards
      idExMemRead = 1'b1; idExRd = 5'd0; ifIdRs1 = 5'd0; ifIdRs2 = 5'd0; #1;
      chk("x0_hazard", 32'(hazard), 32'd0);
      chk("x0_pcWrite", 32'(pcWrite), 32'd1);
      // Non-matching registers
      idExRd = 5'd3; ifIdRs1 = 5'd4; ifIdRs2 = 5'd5; #1;
      chk("nomatch_hazard", 32'(hazard), 32'd0);
      // Matching registers but not a load
      idExMemRead = 1'b0; ifIdRs1 = 5'd3; #1;
      chk("noload_hazard", 32'(hazard), 32'd0);
      tick();
      clearIn(); #1;
      chk("x0_stallCnt", stallCnt, 32'd2);

      // Memory handshake with ack on 3rd WAIT cycle
      exMemMemRead = 1'b1; #1;
      chk("mem_run_stall", 32'(stall), 32'd1);
      chk("mem_run_memReq", 32'(memReq), 32'd0);
      chk("mem_run_pcWrite", 32'(pcWrite), 32'd0);
      tick();
      chk("mem_w1_stall", 32'(stall), 32'd1);
      chk("mem_w1_memReq", 32'(memReq), 32'd1);
      tick();
      chk("mem_w2_stall", 32'(stall), 32'd1);
      chk("mem_w2_memReq", 32'(memReq), 32'd1);
      tick();
      chk("mem_w3_memReq", 32'(memReq), 32'd1);
      memAck = 1'b1; #1;
      chk("mem_w3_stall", 32'(stall), 32'd1);
      tick();
      memAck = 1'b0; #1;
      chk("mem_done_stall", 32'(stall), 32'd0);
      chk("mem_done_memReq", 32'(memReq), 32'd0);
      chk("mem_done_pcWrite", 32'(pcWrite), 32'd1);
      chk("mem_done_stallCnt", stallCnt, 32'd6);
      // Back-to-back: re-detect in RUN after DONE
      tick();
      chk("b2b_run_stall", 32'(stall), 32'd1);
      chk("b2b_run_memReq", 32'(memReq), 32'd0);
      memAck = 1'b1;
      tick();
      chk("b2b_w1_memReq", 32'(memReq), 32'd1);
      exMemMemRead = 1'b0;
      tick();
      memAck = 1'b0; #1;
      chk("b2b_done_stall", 32'(stall), 32'd0);
      chk("b2b_done_memReq", 32'(memReq), 32'd0);
      tick();
      chk("b2b_stallCnt", stallCnt, 32'd8);
      // Ack outside WAIT is ignored
      memAck = 1'b1;
      tick();
      memAck = 1'b0; #1;
      chk("stray_ack_stall", 32'(stall), 32'd0);
      chk("stray_ack_memReq", 32'(memReq), 32'd0);
      chk("stray_ack_stallCnt", stallCnt, 32'd8);

      // Load-use plus branch: bubble wins, flush suppressed
      idExMemRead = 1'b1; idExRd = 5'd5; ifIdRs2 = 5'd5; branchTaken = 1'b1; #1;
      chk("sim_hazard", 32'(hazard), 32'd1);
      chk("sim_flush", 32'(flush), 32'd0);
      tick();
      idExMemRead = 1'b0; #1;
      chk("sim_next_flush", 32'(flush), 32'd1);
      chk("sim_next_hazard", 32'(hazard), 32'd0);
      chk("sim_next_pcWrite", 32'(pcWrite), 32'd1);
      chk("sim_stallCnt", stallCnt, 32'd9);
      tick();
      clearIn(); #1;
      chk("sim_flushCnt", flushCnt, 32'd1);
      // Branch and load-use during memory freeze: neither fires
      exMemMemWrite = 1'b1; branchTaken = 1'b1;
      idExMemRead = 1'b1; idExRd = 5'd5; ifIdRs2 = 5'd5; #1;
      chk("frz_stall", 32'(stall), 32'd1);
      chk("frz_flush", 32'(flush), 32'd0);
      chk("frz_hazard", 32'(hazard), 32'd0);
      tick();
      memAck = 1'b1; #1;
      chk("frz_w_flush", 32'(flush), 32'd0);
      tick();
      clearIn(); #1;
      chk("frz_flushCnt", flushCnt, 32'd1);
      chk("frz_stallCnt", stallCnt, 32'd11);
      tick();

      // Reset on 2nd WAIT cycle, ack afterwards is ignored
      exMemMemRead = 1'b1;
      tick();
      tick();
      chk("rw_w2_memReq", 32'(memReq), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0; exMemMemRead = 1'b0; memAck = 1'b1; #1;
      chk("rw_memReq", 32'(memReq), 32'd0);
      chk("rw_stall", 32'(stall), 32'd0);
      chk("rw_stallCnt", stallCnt, 32'd0);
      tick();
      memAck = 1'b0; #1;
      chk("rw_ack_memReq", 32'(memReq), 32'd0);
      chk("rw_ack_stall", 32'(stall), 32'd0);
      chk("rw_ack_stallCnt", stallCnt, 32'd0);

      // Saturation: write held with no ack for 20 cycles
      exMemMemWrite = 1'b1;
      for (int i = 0; i < 14; i++) tick();
      chk("sat_14", 32'(stallCntS), 32'd14);
      tick();
      chk("sat_15", 32'(stallCntS), 32'd15);
      for (int i = 0; i < 5; i++) tick();
      chk("sat_hold", 32'(stallCntS), 32'd15);
      chk("sat_wide", stallCnt, 32'd20);
      chk("sat_memReq", 32'(memReqS), 32'd1);
      chk("sat_flushCnt", 32'(flushCntS), 32'd0);

      clearIn();
      rst = 1'b1;
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that produces the bubble, freeze and flush controls consumed by the ID/EX control-zeroing mux, the PC and the IF/ID register. It detects load-use hazards, resolves taken-branch flushes, and runs a request/acknowledge handshake with the data memory so the whole pipeline freezes while an EX/MEM load or store is outstanding. Saturating counters record stall and flush cycles for performance measurement.

## Interface
- COUNT_W, 32, width of each performance counter
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- idExMemRead_i  input  1  instruction in ID/EX is a load
- idExRd_i  input  5  destination register of the ID/EX instruction
- ifIdRs1_i  input  5  rs1 of the IF/ID instruction
- ifIdRs2_i  input  5  rs2 of the IF/ID instruction
- branchTaken_i  input  1  branch resolved taken in ID this cycle
- exMemMemRead_i  input  1  EX/MEM instruction reads data memory
- exMemMemWrite_i  input  1  EX/MEM instruction writes data memory
- memAck_i  input  1  data memory has completed the outstanding access
- hazardDetected_o  output  1  insert bubble: zero the ID/EX control word
- pcWrite_o  output  1  PC may update
- ifIdWrite_o  output  1  IF/ID may update
- ifIdFlush_o  output  1  clear IF/ID to a NOP
- pipeStall_o  output  1  freeze every pipeline register and the PC
- memReq_o  output  1  data memory request, registered
- stallCount_o  output  COUNT_W  cycles with pipeStall_o or hazardDetected_o high
- flushCount_o  output  COUNT_W  cycles with ifIdFlush_o high

## Operation
- FSM states: RUN, WAIT, DONE. Reset state: RUN.
- memAccess = exMemMemRead_i | exMemMemWrite_i.
- RUN: if memAccess, then pipeStall_o=1 (combinational) and next state WAIT; otherwise, stay in RUN.
- WAIT: pipeStall_o=1 and memReq_o=1. When memAck_i=1, next state is DONE; otherwise, stay in WAIT.
- DONE: pipeStall_o=0, memReq_o=0, and the pipeline advances so the access retires. memAccess is ignored here, which prevents a re-request for the same instruction. Next state is RUN unconditionally.
- memReq_o is a flop: 1 exactly while in WAIT, so it rises on the edge entering WAIT and falls on the edge leaving it.
- loadUse = idExMemRead_i & (idExRd_i != 0) & (idExRd_i == ifIdRs1_i | idExRd_i == ifIdRs2_i).
- hazardDetected_o = loadUse & ~pipeStall_o.
- pcWrite_o = ifIdWrite_o = ~(pipeStall_o | hazardDetected_o).
- ifIdFlush_o = branchTaken_i & ~pipeStall_o & ~hazardDetected_o.
- Priority: memory freeze, then load-use bubble, then branch flush.
  - On a simultaneous load-use and taken branch, the flush is suppressed; the branch re-resolves on the following cycle.
- memAck_i is ignored outside WAIT.
- Counters:
  - stallCount_o increments on each clock with (pipeStall_o | hazardDetected_o).
  - flushCount_o increments on each clock with ifIdFlush_o.
  - Both saturate at all-ones, never wrap, and are not incremented during the reset cycle.
- Reset values: state RUN, memReq_o=0, stallCount_o=0, flushCount_o=0.
  - Combinational outputs follow from state RUN plus the current inputs.
- Reset mid-handshake (in WAIT): next state RUN and memReq_o=0 after that edge. An ack arriving later is ignored.

## Timing
- Load-use detection and branch flush are same-cycle combinational, with zero latency.
- The memory freeze asserts in the same cycle memAccess is seen in RUN.
- Minimum memory stall is 2 cycles (RUN-detect cycle plus one WAIT cycle with ack). This is followed by 1 DONE cycle with no stall.
- An ack on the k-th WAIT cycle gives k+1 stall cycles.
- Back-to-back memory instructions: DONE then RUN re-detects the next access, so there is at most one unstalled cycle between accesses.
- A load-use bubble lasts exactly 1 cycle per load, because the load leaves ID/EX on the next edge.

## Test plan
- Reset then idle:
  - Stimulus: rst_i=1 for 2 cycles, all inputs 0.
  - Required: pcWrite_o=ifIdWrite_o=1; all other outputs 0; both counters 0.
- Load-use:
  - Stimulus: idExMemRead_i=1, idExRd_i=5, ifIdRs2_i=5 for 1 cycle.
  - Required: hazardDetected_o=1 and pcWrite_o=ifIdWrite_o=0 that cycle; stallCount_o=1 after.
  - Repeat with idExRd_i=0: no hazard.
- Memory handshake:
  - Stimulus: exMemMemRead_i=1; memAck_i=1 on the 3rd cycle after memReq_o rises.
  - Required: pipeStall_o high for 4 cycles; memReq_o high for 3; DONE cycle with pipeStall_o=0 even though exMemMemRead_i is still 1; stallCount_o=4.
- Simultaneous events:
  - Stimulus: load-use plus branchTaken_i in the same cycle.
  - Required: hazardDetected_o=1, ifIdFlush_o=0.
  - Next cycle, with loadUse cleared and the branch still taken: ifIdFlush_o=1, flushCount_o=1.
  - A branch during a memory freeze produces no flush.
- Reset in WAIT:
  - Stimulus: assert rst_i on the 2nd WAIT cycle, then memAck_i=1 one cycle later.
  - Required: memReq_o=0 after the reset edge; state RUN; the ack has no effect.
- Saturation:
  - Stimulus: COUNT_W=4, hold exMemMemWrite_i=1 with no ack for 20 cycles.
  - Required: stallCount_o reaches 15 and stays at 15.
